ram_sp_bist: RTL and testbench
==============================

# ram_sp_bist

March C- built-in self-test initiator for the single-ported synchronous RAM. It drives the RAM's write-enable, address and data-input pins and checks the RAM's data output, then reports pass/fail with the first failing address. It sits between the RAM and system control logic, and owns the RAM port only while `busy` is high.

## Interface
- `DATA_WIDTH`, 8, RAM word width.
- `ADDR_WIDTH`, 8, RAM address width.
- `RAM_DEPTH`, `1 << ADDR_WIDTH`, number of words tested (N).
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; sampled only in IDLE and DONE.
- `busy`  out  1  high while the march runs.
- `done`  out  1  high from end of run until the next accepted `start` or `reset`.
- `pass`  out  1  valid while `done`=1; 1 = no mismatch.
- `fail_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `fail_elem`  out  3  march element (1–5) of the first mismatch.
- `ram_we`  out  1  RAM write enable.
- `ram_a`  out  ADDR_WIDTH  RAM address.
- `ram_di`  out  DATA_WIDTH  RAM write data.
- `ram_do`  in  DATA_WIDTH  RAM read data.

## Operation
- RAM contract:
  - Write when `ram_we`=1 at the clock edge.
  - The address is registered every edge.
  - `ram_do` shows the word at the address registered at the last edge (one-cycle read latency; write-first on the same address).
- March sequence. D0 = all zeros, D1 = all ones. ⇑ = address 0→N-1, ⇓ = address N-1→0.
  - M0: ⇑ w0.
  - M1: ⇑ (r0, w1).
  - M2: ⇑ (r1, w0).
  - M3: ⇓ (r0, w1).
  - M4: ⇓ (r1, w0).
  - M5: ⇓ r0.
- States: IDLE → M0 → M1 → M2 → M3 → M4 → M5 → CHK → DONE. DONE → M0 on `start`.
- M0: one cycle per address. `ram_we`=1, `ram_di`=D0.
- M1–M4: two cycles per address.
  - Cycle R: `ram_we`=0, `ram_a`=addr.
  - Cycle W: `ram_we`=1, same addr, `ram_di`=write value; compare `ram_do` against the expected value this cycle.
- M5: one cycle per address, `ram_we`=0.
  - The read of address i is compared in the following cycle, while address i+1 is presented.
  - CHK compares the read of address 0.
- Mismatch means any bit differs from the expected word.
- On the first mismatch of a run, register `fail_addr`/`fail_elem` and latch an error flag. Later mismatches do not overwrite them.
- Address counter wraps cleanly at the ends: ⇑ ends at N-1, ⇓ ends at 0. The counter never passes through an out-of-range value.
- Outside M0–M5: `ram_we`=0, `ram_a`=0, `ram_di`=0.
- `start` while `busy` is ignored.
- A new `start` in DONE clears `done`, `pass` and the fail registers, and begins M0 on the next cycle.
- Reset mid-run: the next cycle is IDLE with all outputs at reset values. No further RAM writes occur, and RAM contents are left undefined.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_elem`=0, `ram_we`=0, `ram_a`=0, `ram_di`=0.
- `start` high at edge t: `busy`=1 and the M0 address-0 write are driven in the cycle after t.
- Full run: `busy` high for exactly 10N+1 cycles (N + 8N + N + 1 for CHK).
- `done`=1 and `pass` valid in the cycle after CHK, with `busy`=0 in that same cycle.
- `pass`, `fail_addr` and `fail_elem` are stable for as long as `done`=1.

## Configuration
- `RAM_BIST_STOP_ON_FAIL_EN` defined:
  - The first mismatch ends the run. The next cycle is DONE with `pass`=0 and `ram_we`=0.
  - The W-cycle write performed during the failing compare cycle still occurs.
- Not defined: the full sequence always runs to completion (10N+1 cycles), recording only the first failure.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4 (N=16).
- Fault-free RAM model, `start` pulse → `busy` high 161 cycles, then `done`=1, `pass`=1; `fail_addr`/`fail_elem` = 0.
- Bit 3 of address 5 stuck at 1 → `pass`=0, `fail_addr`=5, `fail_elem`=1.
  - With the macro: `done` follows the M1 address-5 compare by one cycle.
  - Without the macro: `done` at cycle 161.
- Address decoder fault (writes to 9 land in 8, reads of 9 return word 8) → `pass`=0, `fail_addr`=9, `fail_elem`=1.
- `start` re-pulsed at cycle 40 of a run → ignored; run still ends at cycle 161 with `pass`=1.
- `reset` asserted at cycle 50 → next cycle all outputs at reset values and `ram_we`=0; a subsequent `start` gives a clean 161-cycle pass.
- Second `start` after a failing run on the fault-free model → `done` drops the next cycle; the run ends with `pass`=1, `fail_addr`=0, `fail_elem`=0.

Source files
------------

// File: rtl/ram_sp_bist.sv
// March C- self-test initiator for a single-port synchronous RAM (one-cycle read latency).
// Define RAM_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module ram_sp_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [DATA_WIDTH-1:0] ram_di,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHK, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] D0     = '0;
    localparam logic [DATA_WIDTH-1:0] D1     = '1;

    state_t                r_state, w_state_nx;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
    logic                  r_wphase, w_wphase_nx;
    logic                  r_err, w_err_nx;
    logic [ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr_nx;
    logic [2:0]            r_fail_elem, w_fail_elem_nx;

    logic                  w_cmp_en;
    logic [DATA_WIDTH-1:0] w_exp;
    logic [ADDR_WIDTH-1:0] w_cmp_addr;
    logic [2:0]            w_cmp_elem;
    logic                  w_mismatch;

    // M5 reads land one cycle late, so the compared address trails the presented one.
    always_comb begin
        w_cmp_en   = 1'b0;
        w_exp      = D0;
        w_cmp_addr = r_addr;
        w_cmp_elem = 3'd0;
        case (r_state)
            S_M1: begin w_cmp_en = r_wphase; w_exp = D0; w_cmp_elem = 3'd1; end
            S_M2: begin w_cmp_en = r_wphase; w_exp = D1; w_cmp_elem = 3'd2; end
            S_M3: begin w_cmp_en = r_wphase; w_exp = D0; w_cmp_elem = 3'd3; end
            S_M4: begin w_cmp_en = r_wphase; w_exp = D1; w_cmp_elem = 3'd4; end
            S_M5: begin
                w_cmp_en   = (r_addr != A_LAST);
                w_cmp_addr = r_addr + A_ONE;
                w_cmp_elem = 3'd5;
            end
            S_CHK: begin
                w_cmp_en   = 1'b1;
                w_cmp_addr = '0;
                w_cmp_elem = 3'd5;
            end
            default: ;
        endcase
    end

    assign w_mismatch = w_cmp_en && (ram_do != w_exp);

    always_comb begin
        w_state_nx     = r_state;
        w_addr_nx      = r_addr;
        w_wphase_nx    = r_wphase;
        w_err_nx       = r_err;
        w_fail_addr_nx = r_fail_addr;
        w_fail_elem_nx = r_fail_elem;
        if (w_mismatch && !r_err) begin
            w_err_nx       = 1'b1;
            w_fail_addr_nx = w_cmp_addr;
            w_fail_elem_nx = w_cmp_elem;
        end
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nx     = S_M0;
                    w_addr_nx      = '0;
                    w_wphase_nx    = 1'b0;
                    w_err_nx       = 1'b0;
                    w_fail_addr_nx = '0;
                    w_fail_elem_nx = '0;
                end
            end
            S_M0: begin
                if (r_addr == A_LAST) begin
                    w_state_nx = S_M1;
                    w_addr_nx  = '0;
                end else begin
                    w_addr_nx = r_addr + A_ONE;
                end
            end
            S_M1, S_M2: begin
                w_wphase_nx = !r_wphase;
                if (r_wphase) begin
                    if (r_addr == A_LAST) begin
                        w_state_nx = (r_state == S_M1) ? S_M2 : S_M3;
                        w_addr_nx  = (r_state == S_M1) ? '0 : A_LAST;
                    end else begin
                        w_addr_nx = r_addr + A_ONE;
                    end
                end
            end
            S_M3, S_M4: begin
                w_wphase_nx = !r_wphase;
                if (r_wphase) begin
                    if (r_addr == '0) begin
                        w_state_nx = (r_state == S_M3) ? S_M4 : S_M5;
                        w_addr_nx  = A_LAST;
                    end else begin
                        w_addr_nx = r_addr - A_ONE;
                    end
                end
            end
            S_M5: begin
                if (r_addr == '0) w_state_nx = S_CHK;
                else              w_addr_nx  = r_addr - A_ONE;
            end
            S_CHK: begin
                w_state_nx = S_DONE;
                w_addr_nx  = '0;
            end
            default: w_state_nx = S_IDLE;
        endcase
`ifdef RAM_BIST_STOP_ON_FAIL_EN
        if (w_mismatch) begin
            w_state_nx  = S_DONE;
            w_addr_nx   = '0;
            w_wphase_nx = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wphase    <= 1'b0;
            r_err       <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_addr      <= w_addr_nx;
            r_wphase    <= w_wphase_nx;
            r_err       <= w_err_nx;
            r_fail_addr <= w_fail_addr_nx;
            r_fail_elem <= w_fail_elem_nx;
        end
    end

    always_comb begin
        busy   = 1'b0;
        ram_we = 1'b0;
        ram_a  = '0;
        ram_di = '0;
        case (r_state)
            S_M0: begin
                busy   = 1'b1;
                ram_we = 1'b1;
                ram_a  = r_addr;
            end
            S_M1, S_M3: begin
                busy   = 1'b1;
                ram_we = r_wphase;
                ram_a  = r_addr;
                ram_di = r_wphase ? D1 : D0;
            end
            S_M2, S_M4: begin
                busy   = 1'b1;
                ram_we = r_wphase;
                ram_a  = r_addr;
            end
            S_M5: begin
                busy  = 1'b1;
                ram_a = r_addr;
            end
            S_CHK:   busy = 1'b1;
            default: ;
        endcase
    end

    assign done      = (r_state == S_DONE);
    assign pass      = done && !r_err;
    assign fail_addr = r_fail_addr;
    assign fail_elem = r_fail_elem;

endmodule

// File: tb/tb_ram_sp_bist.sv
// Bench for ram_sp_bist: faultable RAM model, per-cycle expected-output queue from a march model.
module tb_ram_sp_bist;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N  = 16;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do;

    always #5 clock = ~clock;

    ram_sp_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_elem(fail_elem),
        .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
    );

    // 0: fault-free, 1: addr 5 bit 3 stuck at 1, 2: addr 9 aliased onto word 8
    int fault_mode = 0;

    function automatic logic [AW-1:0] phys(input logic [AW-1:0] a, input int mode);
        return (mode == 2 && a == 4'd9) ? 4'd8 : a;
    endfunction

    logic [DW-1:0] mem [N];
    logic [AW-1:0] r_ram_a;

    always @(posedge clock) begin
        if (ram_we) mem[phys(ram_a, fault_mode)] <= ram_di;
        r_ram_a <= ram_a;
    end

    always_comb begin
        ram_do = mem[phys(r_ram_a, fault_mode)];
        if (fault_mode == 1 && r_ram_a == 4'd5) ram_do = ram_do | 8'h08;
    end

    typedef struct packed {
        logic          busy;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] di;
        logic          done;
        logic          pass;
        logic          chk_fail;
        logic [AW-1:0] fa;
        logic [2:0]    fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %h, need %h", name, $time, act, req);
    endtask

    function automatic exp_t mk_run(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] di);
        exp_t e;
        e = '0;
        e.busy = 1'b1;
        e.we   = we;
        e.a    = a;
        e.di   = di;
        return e;
    endfunction

    function automatic exp_t mk_idle(input logic dn, input logic ps, input logic [AW-1:0] fa,
                                     input logic [2:0] fe);
        exp_t e;
        e = '0;
        e.done     = dn;
        e.pass     = ps;
        e.chk_fail = 1'b1;
        e.fa       = fa;
        e.fe       = fe;
        return e;
    endfunction

    always @(negedge clock) begin : cmp
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ports", 32'({busy, ram_we, ram_a, ram_di, done, pass}),
                  32'({e.busy, e.we, e.a, e.di, e.done, e.pass}));
            if (e.chk_fail) check("fail_regs", 32'({fail_addr, fail_elem}), 32'({e.fa, e.fe}));
        end
        if (busy) busy_cnt++;
    end

    // Reference march: abstract memory with the same fault as the RAM model.
    logic [DW-1:0] mdl_mem [N];

    function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
        return mdl_mem[phys(a, fault_mode)] | ((fault_mode == 1 && a == 4'd5) ? 8'h08 : 8'h00);
    endfunction

    task automatic mwr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mdl_mem[phys(a, fault_mode)] = d;
    endtask

    task automatic build_run(output int len);
        bit            err, stopped;
        logic [AW-1:0] efa, a;
        logic [2:0]    efe;
        logic [DW-1:0] rv, wv, got;
        bit            up;
        len = 0; err = 0; stopped = 0; efa = '0; efe = '0;
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(mk_run(1'b1, AW'(k), 8'h00));
            mwr(AW'(k), 8'h00);
            len++;
        end
        for (int el = 1; el <= 4 && !stopped; el++) begin
            up = (el <= 2);
            rv = (el == 1 || el == 3) ? 8'h00 : 8'hFF;
            wv = ~rv;
            for (int k = 0; k < N && !stopped; k++) begin
                a = up ? AW'(k) : AW'(N - 1 - k);
                exp_q.push_back(mk_run(1'b0, a, 8'h00));
                exp_q.push_back(mk_run(1'b1, a, wv));
                len += 2;
                got = mrd(a);
                mwr(a, wv);
                if (got != rv && !err) begin
                    err = 1; efa = a; efe = 3'(el);
                    stopped = STOP;
                end
            end
        end
        for (int k = 0; k <= N && !stopped; k++) begin
            exp_q.push_back(mk_run(1'b0, (k < N) ? AW'(N - 1 - k) : AW'(0), 8'h00));
            len++;
            if (k > 0) begin
                a = AW'(N - k);
                if (mrd(a) != 8'h00 && !err) begin
                    err = 1; efa = a; efe = 3'd5;
                    stopped = STOP;
                end
            end
        end
        repeat (3) exp_q.push_back(mk_idle(1'b1, !err, efa, efe));
    endtask

    task automatic start_run(output int len);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        busy_cnt = 0;
        build_run(len);
    endtask

    task automatic wait_empty(input int bound);
        int c = 0;
        while (exp_q.size() > 0 && c < bound) begin
            @(negedge clock); #1;
            c++;
        end
        if (exp_q.size() > 0) begin
            check("timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic pulse_start_at(input int cyc);
        repeat (cyc - 1) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int len, s, gap;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock); #1;
        repeat (2) exp_q.push_back(mk_idle(1'b0, 1'b0, '0, '0));
        @(posedge clock); @(posedge clock); #1 reset = 1'b0;
        wait_empty(10);

        // fault-free run
        start_run(len);
        wait_empty(400);
        check("busy_len_clean", 32'(busy_cnt), 32'd161);
        check("pass_clean", 32'({done, pass, fail_addr, fail_elem}), 32'({1'b1, 1'b1, 4'd0, 3'd0}));

        // stuck-at bit 3 at address 5
        fault_mode = 1;
        start_run(len);
        wait_empty(400);
        check("busy_len_stuck", 32'(busy_cnt), 32'(STOP ? 28 : 161));
        check("fail_stuck", 32'({done, pass, fail_addr, fail_elem}), 32'({1'b1, 1'b0, 4'd5, 3'd1}));

        // decoder alias 9 -> 8
        fault_mode = 2;
        start_run(len);
        wait_empty(400);
        check("busy_len_dec", 32'(busy_cnt), 32'(STOP ? 36 : 161));
        check("fail_dec", 32'({done, pass, fail_addr, fail_elem}), 32'({1'b1, 1'b0, 4'd9, 3'd1}));

        // restart from a failing DONE on the fault-free RAM
        fault_mode = 0;
        start_run(len);
        wait_empty(400);
        check("restart_pass", 32'({done, pass, fail_addr, fail_elem}), 32'({1'b1, 1'b1, 4'd0, 3'd0}));

        // start re-pulsed at cycle 40 is ignored
        start_run(len);
        pulse_start_at(40);
        wait_empty(400);
        check("busy_len_restart40", 32'(busy_cnt), 32'd161);
        check("pass_restart40", 32'(pass), 32'd1);

        // reset at cycle 50
        start_run(len);
        repeat (49) @(posedge clock);
        #1 reset = 1'b1;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        repeat (2) exp_q.push_back(mk_idle(1'b0, 1'b0, '0, '0));
        @(posedge clock); #1 reset = 1'b0;
        wait_empty(10);
        start_run(len);
        wait_empty(400);
        check("busy_len_after_reset", 32'(busy_cnt), 32'd161);
        check("pass_after_reset", 32'({pass, fail_addr, fail_elem}), 32'({1'b1, 4'd0, 3'd0}));

        // randomized runs with spurious start pulses while busy
        repeat (5) begin
            fault_mode = int'($urandom_range(0, 2));
            gap = int'($urandom_range(0, 5));
            repeat (gap) @(posedge clock);
            start_run(len);
            s = int'($urandom_range(2, len));
            pulse_start_at(s);
            wait_empty(400);
            check("busy_len_rand", 32'(busy_cnt), 32'(len));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
